e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It is the multi-cycle counterpart to the combinational E-stage ALU: it consumes the same forwarded operand pair but completes over several cycles into private HI/LO registers. It exposes a busy handshake so the hazard unit can stall dependent MDU instructions.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- A  input  32  operand rs (forwarded)
- B  input  32  operand rt (forwarded)
- MDUop  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved (no-op)
- start  input  1  qualifies MDUop for this cycle; one-cycle pulse per instruction
- busy  output  1  operation in flight
- HI  output  32  architectural HI (for mfhi)
- LO  output  32  architectural LO (for mflo)

## Operation
- State: HI, LO, busy, cycle counter cnt, pending result regs pHI/pLO, pending-valid flag.
- Two states: IDLE (busy=0) and RUN (busy=1).
- IDLE, start=1, MDUop mult/multu/div/divu: capture result into pHI/pLO at the edge; load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
- Results:
  - mult: {pHI,pLO} = $signed(A)*$signed(B), 64-bit.
  - multu: unsigned 64-bit product.
  - div: pLO = signed quotient truncated toward zero; pHI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B=0) for div/divu: still runs DIV_CYCLES with busy=1; HI/LO left unchanged at completion.
- RUN: cnt decrements each edge. At the edge where cnt goes 1→0: HI←pHI, LO←pLO (unless div-by-zero), busy←0, return to IDLE.
- mthi/mtlo with start=1 in IDLE: HI←A (or LO←A) at that edge; busy stays 0.
- Reserved MDUop with start=1: no state change.
- start=1 while busy=1: ignored entirely, for all ops including mthi/mtlo. The hazard unit guarantees this by stalling on (start|busy) for MDU instructions; the unit does not queue.
- HI/LO outputs are the committed registers only. Pending results are never visible before completion.

## Timing
- Reset (async, any time, including mid-RUN): HI=0, LO=0, busy=0, cnt=0, pending cleared, state IDLE. An in-flight operation is discarded.
- start sampled at edge t → busy=1 from after t for exactly N cycles (N=5 or 10). busy falls at edge t+N, where HI/LO also update; new values are readable the same cycle busy reads 0.
- mthi/mtlo: HI/LO visible one cycle after the start edge; zero busy cycles.
- Back-to-back: a start in the first cycle where busy=0 is accepted. No dead cycle.
- Operands A/B are sampled only at the start edge; later changes have no effect.
- All arithmetic is 32-bit in and 64-bit product. No overflow signalling.

## Test plan
- Reset then idle: HI=0, LO=0, busy=0. Assert reset mid-div (cycle 4 of 10) → busy drops immediately, HI/LO=0, no later commit.
- mult A=0xFFFFFFFE(-2), B=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7, B=2 → busy high 10 cycles; then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). divu A=7, B=2 → LO=3, HI=1.
- div with B=0 after mthi 0x1234/mtlo 0x5678 → busy high 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- start=1 mthi A=0xAAAA during a running mult → ignored; HI equals the mult result at completion. A new mult issued the cycle busy falls is accepted and busy re-rises immediately.
- Change A/B every cycle during RUN → result matches operands captured at the start edge.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: captures a 64-bit result at the start edge,
// holds busy for a fixed latency, then commits into the architectural HI/LO registers.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        phi_q, phi_d;
    logic [31:0]        plo_q, plo_d;
    logic               pvalid_q, pvalid_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] dividend, divisor, quo_mag, rem_mag, quo, rem;

    // Sign-extended 64x64 multiply keeps the low 64 bits equal to the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide goes through magnitudes so -2^31 / -1 stays well defined.
    always_comb begin
        div_signed = (MDUop == OP_DIV);
        dividend   = A;
        divisor    = B;
        if (div_signed) begin
            dividend = A[31] ? (~A + 32'd1) : A;
            divisor  = B[31] ? (~B + 32'd1) : B;
        end
        quo_mag = 32'd0;
        rem_mag = 32'd0;
        if (divisor != 32'd0) begin
            quo_mag = dividend / divisor;
            rem_mag = dividend % divisor;
        end
        quo = quo_mag;
        rem = rem_mag;
        if (div_signed) begin
            quo = (A[31] ^ B[31]) ? (~quo_mag + 32'd1) : quo_mag;
            rem = A[31] ? (~rem_mag + 32'd1) : rem_mag;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        pvalid_d = pvalid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDUop)
                        OP_MULT: begin
                            phi_d    = prod_s[63:32];
                            plo_d    = prod_s[31:0];
                            pvalid_d = 1'b1;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                            state_d  = RUN;
                        end
                        OP_MULTU: begin
                            phi_d    = prod_u[63:32];
                            plo_d    = prod_u[31:0];
                            pvalid_d = 1'b1;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                            state_d  = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            phi_d    = rem;
                            plo_d    = quo;
                            pvalid_d = (B != 32'd0);
                            cnt_d    = CNT_W'(DIV_CYCLES);
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    pvalid_d = 1'b0;
                    if (pvalid_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            phi_q    <= 32'd0;
            plo_q    <= 32'd0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed and randomized bench for e_mdu against an arithmetic reference of HI/LO.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  MDUop;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop),
        .start(start), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {commit, hi, lo}
    function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; return {1'b1, p[63:32], p[31:0]}; end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; return {1'b1, u}; end
            3'd2: begin
                if (b == 0) return {1'b0, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {1'b0, 64'd0};
                return {1'b1, a % b, a / b};
            end
            default: return {1'b0, 64'd0};
        endcase
    endfunction

    // Called at a negedge with busy=0. Leaves the bench at the negedge where the
    // committed result must be visible. mode: 0 quiet, 1 inject mthi 0xAAAA, 2 random noise.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        logic [64:0] res;
        int n;
        A = a; B = b; MDUop = op; start = 1'b1;
        res = ref_op(op, a, b);
        @(negedge clk);
        start = 1'b0;
        if (op == 3'd4) hi_m = a;
        else if (op == 3'd5) lo_m = a;
        if (op > 3'd3) begin
            chk("busy_mt", {31'd0, busy}, 32'd0);
            chk("hi_mt", HI, hi_m);
            chk("lo_mt", LO, lo_m);
            return;
        end
        n = (op <= 3'd1) ? MC : DC;
        for (int i = 0; i < n; i++) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("hi_hold", HI, hi_m);
            chk("lo_hold", LO, lo_m);
            start = 1'b0;
            if (mode == 1 && i == 1) begin
                start = 1'b1; MDUop = 3'd4; A = 32'h0000AAAA;
            end else if (mode == 2) begin
                A = $urandom; B = $urandom;
                start = 1'($urandom_range(0, 1));
                MDUop = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (res[64]) begin
            hi_m = res[63:32];
            lo_m = res[31:0];
        end
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("hi_done", HI, hi_m);
        chk("lo_done", LO, lo_m);
    endtask

    initial begin
        logic [2:0] op;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; MDUop = '0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 0);
        chk("multu_hi", HI, 32'h00000002);
        chk("multu_lo", LO, 32'hFFFFFFFA);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);
        run_op(3'd3, 32'd7, 32'd2, 0);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);

        run_op(3'd4, 32'h1234, 32'd0, 0);
        run_op(3'd5, 32'h5678, 32'd0, 0);
        run_op(3'd2, 32'd99, 32'd0, 0);
        chk("dz_hi", HI, 32'h1234);
        chk("dz_lo", LO, 32'h5678);
        run_op(3'd3, 32'd5, 32'd0, 0);
        chk("dzu_lo", LO, 32'h5678);

        run_op(3'd6, 32'hDEAD, 32'hBEEF, 0);
        run_op(3'd7, 32'hDEAD, 32'hBEEF, 0);

        run_op(3'd0, 32'd1000, 32'hFFFFFFFF, 1);
        chk("ign_hi", HI, 32'hFFFFFFFF);
        chk("ign_lo", LO, 32'hFFFFFC18);
        // issued immediately in the first cycle busy reads 0
        run_op(3'd1, 32'h80000000, 32'h80000000, 0);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_lo", LO, 32'h80000000);

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
            run_op(op, ra, rb, 2);
        end

        A = 32'd500; B = 32'd7; MDUop = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        hi_m = 32'd0; lo_m = 32'd0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", HI, 32'd0);
        chk("mid_rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DC + 2; i++) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", HI, 32'd0);
        chk("post_rst_lo", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
